// File: rtl/witf_scb_pkg.sv
// Shared constants and width helpers for the writeback instruction track scoreboard.
package witf_scb_pkg;

    localparam int WITF_DEPTH = 4;   // default number of tracked instructions
    localparam int WITF_RAW_W = 5;   // default register index width

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int witf_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Pointer width: at least one bit so a single-entry table still has an index.
    function automatic int witf_aw(input int depth);
        return (witf_clog2(depth) < 1) ? 1 : witf_clog2(depth);
    endfunction

endpackage

// File: rtl/witf_scb_if.sv
// Dispatch / writeback bundle of the scoreboard.
interface witf_scb_if #(
    parameter int RAW_W = 5,
    parameter int AW    = 2,
    parameter int CW    = 3
);
    logic             disp_valid;
    logic             disp_rd_wen;
    logic [RAW_W-1:0] disp_rd;
    logic             disp_rs1_en;
    logic [RAW_W-1:0] disp_rs1;
    logic             disp_rs2_en;
    logic [RAW_W-1:0] disp_rs2;
    logic             disp_ready;
    logic [AW-1:0]    disp_tag;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             wb_valid;
    logic [RAW_W-1:0] wb_rd;
    logic             wb_rd_wen;
    logic             wb_err;
    logic             flush;
    logic             witf_full;
    logic             witf_empty;
    logic [CW-1:0]    count;

    modport master (
        output disp_valid, disp_rd_wen, disp_rd, disp_rs1_en, disp_rs1,
               disp_rs2_en, disp_rs2, wb_valid, flush,
        input  disp_ready, disp_tag, raw_hazard, waw_hazard, wb_rd,
               wb_rd_wen, wb_err, witf_full, witf_empty, count
    );

    modport slave (
        input  disp_valid, disp_rd_wen, disp_rd, disp_rs1_en, disp_rs1,
               disp_rs2_en, disp_rs2, wb_valid, flush,
        output disp_ready, disp_tag, raw_hazard, waw_hazard, wb_rd,
               wb_rd_wen, wb_err, witf_full, witf_empty, count
    );
endinterface

// File: rtl/witf_scb_ptr.sv
// Circular pointer with wrap flag; the flag flips each time the pointer wraps to 0.
module witf_scb_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [AW-1:0] ptr,
    output logic          flag
);

    // Pointer register: clear wins over advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr  <= '0;
            flag <= 1'b0;
        end else if (clr) begin
            ptr  <= '0;
            flag <= 1'b0;
        end else if (en) begin
            if (ptr == AW'(DEPTH - 1)) begin
                ptr  <= '0;
                flag <= ~flag;
            end else begin
                ptr  <= ptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/witf_scb.sv
// In-order scoreboard: tracks destination registers of in-flight instructions,
// flags RAW/WAW hazards against them and retires them in order on writeback.
module witf_scb import witf_scb_pkg::*; #(
    parameter  int DEPTH     = WITF_DEPTH,
    parameter  int RAW_W     = WITF_RAW_W,
    parameter  int WB_BYPASS = 1,
    localparam int AW        = witf_aw(DEPTH),
    localparam int CW        = witf_clog2(DEPTH + 1)
) (
    input  logic      clk,
    input  logic      rst,
    witf_scb_if.slave bus
);

    localparam bit BYP = (WB_BYPASS != 0);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] rdwen_q;
    logic [RAW_W-1:0] rd_q [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic             err_q;

    logic [AW-1:0]    wptr, rptr;
    logic             wflag, rflag;
    logic             full, empty, pop, skip_head, eff_full, accept;
    logic             raw_any, waw_any;
    logic [DEPTH-1:0] raw_m, waw_m;

    witf_scb_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .clr (bus.flush),
        .ptr (wptr),
        .flag(wflag)
    );

    witf_scb_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .en  (pop & ~bus.flush),
        .clr (bus.flush),
        .ptr (rptr),
        .flag(rflag)
    );

    // A single-entry table has no distinguishing pointer bits, so use the valid bit.
    if (DEPTH == 1) begin : g_fe1
        assign full  = vld_q[0];
        assign empty = ~vld_q[0];
    end else begin : g_fen
        assign full  = (wptr == rptr) & (wflag != rflag);
        assign empty = (wptr == rptr) & (wflag == rflag);
    end

    assign pop       = bus.wb_valid & ~empty;
    // The retiring head no longer blocks anything when bypass is enabled.
    assign skip_head = BYP & pop;
    assign eff_full  = full & ~skip_head;

    // Per-entry matching; x0 is never a hazard source.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic wr;
        assign wr = vld_q[i] & rdwen_q[i] & (rd_q[i] != '0)
                    & ~(skip_head & (rptr == AW'(i)));
        assign raw_m[i] = wr & ((bus.disp_rs1_en & (rd_q[i] == bus.disp_rs1)) |
                                (bus.disp_rs2_en & (rd_q[i] == bus.disp_rs2)));
        assign waw_m[i] = wr & bus.disp_rd_wen & (bus.disp_rd != '0)
                          & (rd_q[i] == bus.disp_rd);
    end

    assign raw_any = |raw_m;
    assign waw_any = |waw_m;
    assign accept  = bus.disp_valid & bus.disp_ready;

    assign bus.raw_hazard = raw_any;
    assign bus.waw_hazard = waw_any;
    assign bus.disp_ready = ~eff_full & ~raw_any & ~waw_any & ~bus.flush;
    assign bus.disp_tag   = wptr;
    assign bus.wb_rd      = empty ? '0 : rd_q[rptr];
    assign bus.wb_rd_wen  = empty ? 1'b0 : rdwen_q[rptr];
    assign bus.wb_err     = err_q;
    assign bus.witf_full  = full;
    assign bus.witf_empty = empty;
    assign bus.count      = cnt_q;

    // Valid bits: flush clears all; the set follows the clear so a full-table
    // bypass refill of the retiring slot leaves it valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (bus.flush) begin
            vld_q <= '0;
        end else begin
            if (pop)    vld_q[rptr] <= 1'b0;
            if (accept) vld_q[wptr] <= 1'b1;
        end
    end

    // Payload is only ever observed through a set valid bit, so it is not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q[wptr]    <= bus.disp_rd;
            rdwen_q[wptr] <= bus.disp_rd_wen;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (accept & ~pop) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (pop & ~accept) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Underflow pulse: writeback seen with nothing in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bus.wb_valid & empty & ~bus.flush;
        end
    end

endmodule

// File: tb/tb_witf_scb.sv
// Bench for witf_scb: a bypass and a non-bypass instance share stimulus and are
// each checked against a queue-based reference model, plus directed vectors.
module tb_witf_scb;

    localparam int DEPTH = 4;
    localparam int RAW_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    witf_scb_if #(.RAW_W(RAW_W), .AW(2), .CW(3)) bus0 ();
    witf_scb_if #(.RAW_W(RAW_W), .AW(2), .CW(3)) bus1 ();

    witf_scb #(.DEPTH(DEPTH), .RAW_W(RAW_W), .WB_BYPASS(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    witf_scb #(.DEPTH(DEPTH), .RAW_W(RAW_W), .WB_BYPASS(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;

    // current stimulus
    int v_valid, v_wen, v_rd, v_s1e, v_s1, v_s2e, v_s2, v_wb, v_fl;

    // reference model: in-flight instructions, oldest first
    typedef struct { int wen; int rd; } ent_t;
    ent_t q0[$];
    ent_t q1[$];
    int   wtag[2];
    int   merr[2];

    typedef struct {
        int valid, wen, rd, s1e, s1, s2e, s2, wb, fl;
        int e_rdy, e_raw, e_waw, e_cnt, e_full, e_wbrd, e_tag, e_err;
    } vec_t;
    vec_t tbl[24];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus0.disp_valid = v_valid[0];   bus1.disp_valid = v_valid[0];
        bus0.disp_rd_wen = v_wen[0];    bus1.disp_rd_wen = v_wen[0];
        bus0.disp_rd = RAW_W'(v_rd);    bus1.disp_rd = RAW_W'(v_rd);
        bus0.disp_rs1_en = v_s1e[0];    bus1.disp_rs1_en = v_s1e[0];
        bus0.disp_rs1 = RAW_W'(v_s1);   bus1.disp_rs1 = RAW_W'(v_s1);
        bus0.disp_rs2_en = v_s2e[0];    bus1.disp_rs2_en = v_s2e[0];
        bus0.disp_rs2 = RAW_W'(v_s2);   bus1.disp_rs2 = RAW_W'(v_s2);
        bus0.wb_valid = v_wb[0];        bus1.wb_valid = v_wb[0];
        bus0.flush = v_fl[0];           bus1.flush = v_fl[0];
    endtask

    task automatic set_idle();
        v_valid = 0; v_wen = 0; v_rd = 0; v_s1e = 0; v_s1 = 0;
        v_s2e = 0; v_s2 = 0; v_wb = 0; v_fl = 0;
        drive();
    endtask

    // Expected combinational view of instance d from the model and current inputs.
    task automatic predict(input int d, output int rdy, output int raw, output int waw,
                           output int full, output int empty, output int wbrd,
                           output int wbw, output int cnt, output int pop);
        ent_t qq[$];
        int skip;
        if (d == 0) qq = q0; else qq = q1;
        pop  = (v_wb != 0 && qq.size() > 0) ? 1 : 0;
        skip = (d == 0) ? pop : 0;
        raw = 0; waw = 0;
        foreach (qq[i]) begin
            if (!(skip != 0 && i == 0) && qq[i].wen != 0 && qq[i].rd != 0) begin
                if ((v_s1e != 0 && qq[i].rd == v_s1) || (v_s2e != 0 && qq[i].rd == v_s2)) raw = 1;
                if (v_wen != 0 && v_rd != 0 && qq[i].rd == v_rd) waw = 1;
            end
        end
        full  = (qq.size() == DEPTH) ? 1 : 0;
        empty = (qq.size() == 0) ? 1 : 0;
        rdy   = (!(full != 0 && skip == 0) && raw == 0 && waw == 0 && v_fl == 0) ? 1 : 0;
        wbrd  = empty ? 0 : qq[0].rd;
        wbw   = empty ? 0 : qq[0].wen;
        cnt   = qq.size();
    endtask

    task automatic check_model(input int d);
        int rdy, raw, waw, full, empty, wbrd, wbw, cnt, pop;
        string p;
        predict(d, rdy, raw, waw, full, empty, wbrd, wbw, cnt, pop);
        p = (d == 0) ? "byp" : "nobyp";
        if (d == 0) begin
            chk({p, " ready"}, int'(bus0.disp_ready), rdy);
            chk({p, " raw"},   int'(bus0.raw_hazard), raw);
            chk({p, " waw"},   int'(bus0.waw_hazard), waw);
            chk({p, " full"},  int'(bus0.witf_full), full);
            chk({p, " empty"}, int'(bus0.witf_empty), empty);
            chk({p, " wb_rd"}, int'(bus0.wb_rd), wbrd);
            chk({p, " wb_wen"}, int'(bus0.wb_rd_wen), wbw);
            chk({p, " count"}, int'(bus0.count), cnt);
            chk({p, " tag"},   int'(bus0.disp_tag), wtag[0]);
            chk({p, " wb_err"}, int'(bus0.wb_err), merr[0]);
        end else begin
            chk({p, " ready"}, int'(bus1.disp_ready), rdy);
            chk({p, " raw"},   int'(bus1.raw_hazard), raw);
            chk({p, " waw"},   int'(bus1.waw_hazard), waw);
            chk({p, " full"},  int'(bus1.witf_full), full);
            chk({p, " empty"}, int'(bus1.witf_empty), empty);
            chk({p, " wb_rd"}, int'(bus1.wb_rd), wbrd);
            chk({p, " wb_wen"}, int'(bus1.wb_rd_wen), wbw);
            chk({p, " count"}, int'(bus1.count), cnt);
            chk({p, " tag"},   int'(bus1.disp_tag), wtag[1]);
            chk({p, " wb_err"}, int'(bus1.wb_err), merr[1]);
        end
    endtask

    // Advance the model of instance d across one clock edge.
    task automatic update_model(input int d);
        int rdy, raw, waw, full, empty, wbrd, wbw, cnt, pop;
        ent_t e;
        predict(d, rdy, raw, waw, full, empty, wbrd, wbw, cnt, pop);
        if (v_fl != 0) begin
            if (d == 0) q0.delete(); else q1.delete();
            wtag[d] = 0;
            merr[d] = 0;
        end else begin
            merr[d] = (v_wb != 0 && empty != 0) ? 1 : 0;
            if (pop != 0) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (v_valid != 0 && rdy != 0) begin
                e.wen = v_wen; e.rd = v_rd;
                if (d == 0) q0.push_back(e); else q1.push_back(e);
                wtag[d] = (wtag[d] + 1) % DEPTH;
            end
        end
    endtask

    task automatic reset_model();
        q0.delete(); q1.delete();
        wtag[0] = 0; wtag[1] = 0; merr[0] = 0; merr[1] = 0;
    endtask

    // One cycle: inputs already set; sample mid-cycle, then take the edge.
    task automatic step();
        drive();
        #2;
        check_model(0);
        check_model(1);
        @(posedge clk);
        update_model(0);
        update_model(1);
        #1;
    endtask

    initial begin
        // directed vectors; expectations are for the bypass instance
        //          valid wen rd s1e s1 s2e s2 wb fl | rdy raw waw cnt full wbrd tag err
        tbl[0]  = '{1,1,5, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,0};
        tbl[1]  = '{0,0,0, 1,5, 0,0, 0,0,  0,1,0,1,0,5,1,0};
        tbl[2]  = '{0,0,0, 0,0, 0,0, 1,0,  1,0,0,1,0,5,1,0};
        tbl[3]  = '{0,0,0, 1,5, 0,0, 0,0,  1,0,0,0,0,0,1,0};
        tbl[4]  = '{1,1,0, 0,0, 0,0, 0,0,  1,0,0,0,0,0,1,0};
        tbl[5]  = '{1,1,0, 1,0, 0,0, 0,0,  1,0,0,1,0,0,2,0};
        tbl[6]  = '{1,1,6, 0,0, 0,0, 0,0,  1,0,0,2,0,0,3,0};
        tbl[7]  = '{1,1,7, 0,0, 0,0, 0,1,  0,0,0,3,0,0,0,0};
        tbl[8]  = '{0,0,0, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,0};
        tbl[9]  = '{1,1,1, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,0};
        tbl[10] = '{1,1,2, 0,0, 0,0, 0,0,  1,0,0,1,0,1,1,0};
        tbl[11] = '{1,1,3, 0,0, 0,0, 0,0,  1,0,0,2,0,1,2,0};
        tbl[12] = '{1,1,4, 0,0, 0,0, 0,0,  1,0,0,3,0,1,3,0};
        tbl[13] = '{0,0,0, 0,0, 0,0, 0,0,  0,0,0,4,1,1,0,0};
        tbl[14] = '{1,1,9, 0,0, 0,0, 1,0,  1,0,0,4,1,1,0,0};
        tbl[15] = '{0,0,0, 0,0, 0,0, 0,0,  0,0,0,4,1,2,1,0};
        tbl[16] = '{0,0,0, 0,0, 0,0, 1,0,  1,0,0,4,1,2,1,0};
        tbl[17] = '{1,1,10,0,0, 1,3, 1,0,  1,0,0,3,0,3,1,0};
        tbl[18] = '{0,0,0, 0,0, 0,0, 0,0,  1,0,0,3,0,4,2,0};
        tbl[19] = '{0,0,0, 0,0, 0,0, 0,1,  0,0,0,3,0,4,2,0};
        tbl[20] = '{0,0,0, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,0};
        tbl[21] = '{0,0,0, 0,0, 0,0, 1,0,  1,0,0,0,0,0,0,0};
        tbl[22] = '{0,0,0, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,1};
        tbl[23] = '{0,0,0, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,0};

        reset_model();
        set_idle();
        #12;
        chk("reset empty", int'(bus0.witf_empty), 1);
        chk("reset full",  int'(bus0.witf_full), 0);
        chk("reset count", int'(bus0.count), 0);
        chk("reset err",   int'(bus0.wb_err), 0);
        chk("reset tag",   int'(bus0.disp_tag), 0);
        chk("reset empty1", int'(bus1.witf_empty), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            v_valid = tbl[i].valid; v_wen = tbl[i].wen; v_rd = tbl[i].rd;
            v_s1e = tbl[i].s1e; v_s1 = tbl[i].s1; v_s2e = tbl[i].s2e; v_s2 = tbl[i].s2;
            v_wb = tbl[i].wb; v_fl = tbl[i].fl;
            drive();
            #2;
            chk($sformatf("v%0d ready", i), int'(bus0.disp_ready), tbl[i].e_rdy);
            chk($sformatf("v%0d raw", i),   int'(bus0.raw_hazard), tbl[i].e_raw);
            chk($sformatf("v%0d waw", i),   int'(bus0.waw_hazard), tbl[i].e_waw);
            chk($sformatf("v%0d count", i), int'(bus0.count), tbl[i].e_cnt);
            chk($sformatf("v%0d full", i),  int'(bus0.witf_full), tbl[i].e_full);
            chk($sformatf("v%0d wb_rd", i), int'(bus0.wb_rd), tbl[i].e_wbrd);
            chk($sformatf("v%0d tag", i),   int'(bus0.disp_tag), tbl[i].e_tag);
            chk($sformatf("v%0d wb_err", i), int'(bus0.wb_err), tbl[i].e_err);
            check_model(0);
            check_model(1);
            @(posedge clk);
            update_model(0);
            update_model(1);
            #1;
        end

        // head rd=3 retiring while rs2=3 dispatches: bypass accepts, non-bypass blocks
        set_idle(); v_fl = 1; step();
        set_idle(); v_valid = 1; v_wen = 1; v_rd = 3; step();
        set_idle(); v_valid = 1; v_wen = 1; v_rd = 5; step();
        set_idle(); v_valid = 1; v_wen = 1; v_rd = 12; v_s2e = 1; v_s2 = 3; v_wb = 1;
        drive();
        #2;
        chk("bypass rs2 ready", int'(bus0.disp_ready), 1);
        chk("nobypass rs2 ready", int'(bus1.disp_ready), 0);
        chk("nobypass rs2 raw", int'(bus1.raw_hazard), 1);
        @(posedge clk);
        update_model(0);
        update_model(1);
        #1;
        set_idle(); step();

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            v_valid = $urandom_range(0, 1);
            v_wen   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            v_rd    = $urandom_range(0, 7);
            v_s1e   = $urandom_range(0, 1);
            v_s1    = $urandom_range(0, 7);
            v_s2e   = $urandom_range(0, 1);
            v_s2    = $urandom_range(0, 7);
            v_wb    = ($urandom_range(0, 2) == 0) ? 1 : 0;
            v_fl    = ($urandom_range(0, 40) == 0) ? 1 : 0;
            step();
        end

        // asynchronous reset mid-stream, between edges
        set_idle();
        for (int k = 1; k <= 3; k++) begin
            v_valid = 1; v_wen = 1; v_rd = k + 16; step();
        end
        set_idle();
        drive();
        #2;
        rst = 1'b0;
        #1;
        chk("async rst empty", int'(bus0.witf_empty), 1);
        chk("async rst count", int'(bus0.count), 0);
        chk("async rst full",  int'(bus0.witf_full), 0);
        chk("async rst tag",   int'(bus0.disp_tag), 0);
        chk("async rst empty1", int'(bus1.witf_empty), 1);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
        v_valid = 1; v_wen = 1; v_rd = 2; step();
        set_idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/witf_scb.md
Name: witf_scb

Overview:
- Parametrised successor to the writeback instruction track FIFO.
- An in-order scoreboard between dispatch and writeback. It records the destination register of every dispatched instruction and retires entries in order on writeback.
- It flags RAW hazards on both source operands and WAW hazards on the destination, and gates dispatch with a ready signal.
- New over the previous generation: per-entry rd write-enable, x0 exclusion, optional same-cycle writeback bypass, pipeline flush, occupancy count, retired-entry readout and an underflow error flag.

Parameters:
- DEPTH, 4, number of entries; any value >= 1, not required to be a power of 2.
- RAW_W, 5, register index width.
- WB_BYPASS, 1, when 1 the entry retiring this cycle is excluded from hazard and full checks.
- Derived, not overridable: AW = max(1, $clog2(DEPTH)); CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- disp_valid  in  1  dispatch request.
- disp_rd_wen  in  1  instruction writes rd.
- disp_rd  in  RAW_W  destination index.
- disp_rs1_en  in  1  rs1 is read.
- disp_rs1  in  RAW_W  rs1 index.
- disp_rs2_en  in  1  rs2 is read.
- disp_rs2  in  RAW_W  rs2 index.
- disp_ready  out  1  dispatch would be accepted this cycle.
- disp_tag  out  AW  entry index the accepted instruction occupies.
- raw_hazard  out  1  RAW on rs1 or rs2.
- waw_hazard  out  1  WAW on rd.
- wb_valid  in  1  oldest instruction writes back this cycle.
- wb_rd  out  RAW_W  rd of the head entry.
- wb_rd_wen  out  1  rd write-enable of the head entry.
- wb_err  out  1  registered one-cycle pulse: wb_valid arrived while empty.
- flush  in  1  discard all entries.
- witf_full  out  1  all DEPTH entries valid.
- witf_empty  out  1  no valid entries.
- count  out  CW  number of valid entries.

Behaviour:
- Storage
  - Per entry: vld, rdwen, rd.
  - wptr/rptr are AW bits wide, each with a wrap flag. The flag toggles when its pointer advances from DEPTH-1 to 0.
  - empty = pointers equal and flags equal; full = pointers equal and flags differ.
  - For DEPTH = 1, use vld[0] directly for full/empty.
- Entry matching
  - An entry "writes" when vld & rdwen & (rd != 0). x0 is never tracked as a hazard.
- Hazards
  - raw_hazard = any writing entry with rd == disp_rs1 while disp_rs1_en = 1, or with rd == disp_rs2 while disp_rs2_en = 1.
  - waw_hazard = any writing entry with rd == disp_rd while disp_rd_wen = 1 and disp_rd != 0.
  - pop = wb_valid & !empty.
  - If WB_BYPASS = 1 and pop, the head entry (rptr) is excluded from both matches.
- Ready and accept
  - eff_full = full & !(WB_BYPASS & pop).
  - disp_ready = !eff_full & !raw_hazard & !waw_hazard & !flush.
  - accept = disp_valid & disp_ready.
  - Hazard outputs are valid whenever the disp_* inputs are, independent of disp_valid.
- Dispatch (accept)
  - Write {1, disp_rd_wen, disp_rd} into entry wptr; advance wptr.
  - disp_tag = wptr (combinational).
- Writeback (pop)
  - Clear vld[rptr]; advance rptr.
  - wb_rd/wb_rd_wen show the head entry combinationally; they are 0 when empty.
  - wb_valid while empty: no state change; wb_err = 1 next cycle.
- Simultaneous accept and pop: both take effect; count unchanged. When full with WB_BYPASS = 1, the freed slot is the one written.
- Count: count += accept - pop, registered.
- Flush
  - Highest priority: all vld = 0, pointers and flags = 0, count = 0 next cycle.
  - Dispatch and wb in the same cycle are ignored; wb_err is not raised.
- Reset (asserted asynchronously)
  - All vld, pointers, flags, count and wb_err = 0.
  - Outputs after reset: witf_empty = 1, witf_full = 0, count = 0, wb_err = 0, disp_tag = 0.
  - Applies equally mid-operation.
  - Payload registers (rd, rdwen) need no reset; they are only read through vld.
- Latency: hazard, ready, full and empty are combinational on current state and inputs; state changes are visible one cycle after the edge.

Decomposition:
- Shared defines file gains WITF_DEPTH, the register-index width macro, and a clog2 helper if one is not already there.
- A natural sub-module is witf_ptr: a pointer plus wrap flag with enable and clear.
  - Instantiated twice (wptr, rptr).
  - Built on the existing Reg primitive, extended with an asynchronous active-low reset.

Test Plan:
- Reset then dispatch rd = 5 (rd_wen = 1) → next cycle count = 1; a probe with rs1 = 5, rs1_en = 1 gives raw_hazard = 1, disp_ready = 0; after wb_valid, raw_hazard = 0, wb_rd was 5.
- Dispatch rd = 0 with rd_wen = 1 → probe rs1 = 0 gives no RAW; dispatch rd = 0 again gives no WAW.
- DEPTH = 4: dispatch rd = 1..4 → witf_full = 1, count = 4. With WB_BYPASS = 1, wb_valid plus dispatch of rd = 9 in one cycle → accepted, count stays 4, wptr wraps to 0, flags differ.
- With rd = 3 at the head, wb_valid and a dispatch of rs2 = 3 in the same cycle → accepted when WB_BYPASS = 1, blocked when WB_BYPASS = 0.
- wb_valid on empty → no state change, wb_err high for exactly one cycle. Flush with 3 entries plus a concurrent dispatch → next cycle empty, count = 0, no entry written.
- Assert rst mid-stream between clock edges → witf_empty = 1 immediately, before the next clock edge.
